// File: rtl/matrix_pkg.sv
// Shared encodings and the default 7x5 status image table for the LED matrix driver.
package matrix_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    FILLING  = 3'd0,
    CLEANING = 3'd1,
    ERROR    = 3'd2,
    SPLINKER = 3'd3,
    DRIPPER  = 3'd4,
    BLANK    = 3'd7
  } disp_state_e;

  localparam int unsigned DEF_ROWS   = 7;
  localparam int unsigned DEF_COLS   = 5;
  localparam int unsigned DEF_IMAGES = 5;

  // Indexed [image][column]; each word is active-low, bit 6 is the top row.
  localparam logic [6:0] DEFAULT_TABLE [DEF_IMAGES][DEF_COLS] = '{
    '{7'b1101111, 7'b1011111, 7'b0000000, 7'b1011111, 7'b1101111},
    '{7'b1000001, 7'b0111110, 7'b0111110, 7'b0111110, 7'b1011101},
    '{7'b1100011, 7'b1011101, 7'b0111110, 7'b1011101, 7'b1100011},
    '{7'b1001110, 7'b0110110, 7'b0110110, 7'b0110110, 7'b0111001},
    '{7'b1110011, 7'b1100001, 7'b1000000, 7'b1100001, 7'b1110011}
  };

  function automatic logic [31:0] default_column(int unsigned image, int unsigned col,
                                                 int unsigned rows = DEF_ROWS,
                                                 int unsigned cols = DEF_COLS);
    logic [31:0] word;
    word = '1;
    if (rows == DEF_ROWS && cols == DEF_COLS && image < DEF_IMAGES && col < DEF_COLS)
      word[6:0] = DEFAULT_TABLE[image][col];
    return word;
  endfunction

endpackage

// File: rtl/matrix_image_store.sv
// Writable NUM_IMAGES x COLS image store with async reset to the package defaults
// and a combinational read port (a same-edge write is seen by readers one cycle later).
module matrix_image_store
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS       = 7,
  parameter int unsigned COLS       = 5,
  parameter int unsigned NUM_IMAGES = 8,
  localparam int unsigned IW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_image,
  input  logic [CW-1:0]      wr_col,
  input  logic [ROWS-1:0]    wr_data,
  input  logic [STATE_W-1:0] rd_image,
  input  logic [CW-1:0]      rd_col,
  output logic [ROWS-1:0]    rd_data
);

  logic [ROWS-1:0] mem [NUM_IMAGES][COLS];

  function automatic logic [ROWS-1:0] init_word(int unsigned img, int unsigned c);
    logic [31:0] d;
    logic [ROWS-1:0] w;
    d = default_column(img, c, ROWS, COLS);
    w = '1;
    for (int unsigned r = 0; r < ROWS && r < 32; r++) w[r] = d[r];
    return w;
  endfunction

  // Address matching by loop keeps out-of-range writes/reads harmless for any geometry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_IMAGES; i++)
        for (int unsigned j = 0; j < COLS; j++)
          mem[i][j] <= init_word(i, j);
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_IMAGES; i++)
        for (int unsigned j = 0; j < COLS; j++)
          if (32'(wr_image) == i && 32'(wr_col) == j)
            mem[i][j] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '1;
    for (int unsigned i = 0; i < NUM_IMAGES; i++)
      for (int unsigned j = 0; j < COLS; j++)
        if (32'(rd_image) == i && 32'(rd_col) == j)
          rd_data = mem[i][j];
  end

endmodule

// File: rtl/matrix_scan_driver.sv
// Column-scanned LED matrix driver with frame-synchronous image changes and blanking.
// Optional error-image blinking is enabled by defining MATRIX_BLINK_EN.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS         = 7,
  parameter int unsigned COLS         = 5,
  parameter int unsigned NUM_IMAGES   = 8,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 50,
  parameter int unsigned BLINK_FRAMES = 25,
  localparam int unsigned IW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned PW = $clog2(SCAN_DIV)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STATE_W-1:0] state,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_image,
  input  logic [CW-1:0]      wr_col,
  input  logic [ROWS-1:0]    wr_data,
  output logic [ROWS-1:0]    row,
  output logic [COLS-1:0]    col_sel,
  output logic               frame_start
);

  if (SCAN_DIV < 2 || BLANK_CYCLES >= SCAN_DIV || BLINK_FRAMES < 1) begin : g_bad_params
    $error("matrix_scan_driver: invalid SCAN_DIV/BLANK_CYCLES/BLINK_FRAMES");
  end

  logic [PW-1:0]   pcnt;
  logic [CW-1:0]   col_idx;
  disp_state_e     disp_state;
  logic            pcnt_tc;
  logic            col_tc;
  logic            frame_tc;
  logic [ROWS-1:0] rd_data;
  logic [ROWS-1:0] row_next;
  logic [COLS-1:0] col_sel_next;

  assign pcnt_tc  = (32'(pcnt) == SCAN_DIV - 1);
  assign col_tc   = (32'(col_idx) == COLS - 1);
  assign frame_tc = pcnt_tc && col_tc;

  matrix_image_store #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .NUM_IMAGES (NUM_IMAGES)
  ) u_store (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_image (wr_image),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .rd_image (disp_state),
    .rd_col   (col_idx),
    .rd_data  (rd_data)
  );

  // state is sampled only at the frame boundary so a frame never mixes two images.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcnt       <= '0;
      col_idx    <= '0;
      disp_state <= BLANK;
    end else begin
      if (pcnt_tc) begin
        pcnt    <= '0;
        col_idx <= col_tc ? '0 : col_idx + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
      if (frame_tc)
        disp_state <= disp_state_e'(state);
    end
  end

`ifdef MATRIX_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tc) begin
      if (disp_state_e'(state) != disp_state) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (32'(blink_cnt) == BLINK_FRAMES - 1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    row_next = '1;
    if (32'(pcnt) >= BLANK_CYCLES)
      row_next = rd_data;
`ifdef MATRIX_BLINK_EN
    if (disp_state == ERROR && blink_phase)
      row_next = '1;
`endif
    col_sel_next = '0;
    for (int unsigned j = 0; j < COLS; j++)
      col_sel_next[j] = (32'(col_idx) == j);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row         <= '1;
      col_sel     <= '0;
      frame_start <= 1'b0;
    end else begin
      row         <= row_next;
      col_sel     <= col_sel_next;
      frame_start <= (pcnt == '0) && (col_idx == '0);
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed self-checking bench for matrix_scan_driver (7x5, SCAN_DIV=4, BLANK_CYCLES=1).
module tb_matrix_scan_driver;

  typedef logic [6:0] img_t [5];

  localparam img_t BLANK_IMG = '{default: 7'h7F};
  localparam img_t FILL_IMG  = '{7'b1101111, 7'b1011111, 7'b0000000, 7'b1011111, 7'b1101111};
  localparam img_t ERR_IMG   = '{7'b1100011, 7'b1011101, 7'b0111110, 7'b1011101, 7'b1100011};
  localparam img_t SPL_IMG   = '{7'b1001110, 7'b0110110, 7'b0110110, 7'b0110110, 7'b0111001};

`ifdef MATRIX_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] state = 3'd0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_image = 3'd0;
  logic [2:0] wr_col = 3'd0;
  logic [6:0] wr_data = 7'd0;
  logic [6:0] row;
  logic [4:0] col_sel;
  logic       frame_start;

  int unsigned k = 0;
  int n_cmp = 0;
  int n_err = 0;
  img_t cur;

  always #5 clock = ~clock;

  matrix_scan_driver #(
    .ROWS         (7),
    .COLS         (5),
    .NUM_IMAGES   (8),
    .SCAN_DIV     (4),
    .BLANK_CYCLES (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .state       (state),
    .wr_en       (wr_en),
    .wr_image    (wr_image),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .row         (row),
    .col_sel     (col_sel),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    k++;
  endtask

  // After edge k the outputs reflect the counters as they were before that edge.
  task automatic sample(input img_t img);
    int unsigned pre;
    int unsigned p;
    int unsigned c;
    tick();
    pre = k - 1;
    p = pre % 4;
    c = (pre / 4) % 5;
    chk("col_sel", 32'(col_sel), 32'(1) << c);
    chk("frame_start", 32'(frame_start), (pre % 20 == 0) ? 32'd1 : 32'd0);
    chk("row", 32'(row), (p == 0) ? 32'h7F : 32'(img[c]));
  endtask

  task automatic chk_reset_vals();
    chk("rst_row", 32'(row), 32'h7F);
    chk("rst_col_sel", 32'(col_sel), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk_reset_vals();
    reset = 1'b0;
    k = 0;

    for (int i = 0; i < 20; i++) sample(BLANK_IMG);

    for (int i = 0; i < 20; i++) begin
      if (i == 10) state = 3'd3;
      sample(FILL_IMG);
    end

    cur = SPL_IMG;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        wr_en = 1'b1; wr_image = 3'd3; wr_col = 3'd0; wr_data = 7'b0101010;
      end
      if (i == 8 || i == 9) begin
        wr_en = 1'b1; wr_image = 3'd3; wr_col = (i == 8) ? 3'd5 : 3'd7; wr_data = 7'b0000000;
      end
      sample(cur);
      wr_en = 1'b0;
      if (i == 2) cur[0] = 7'b0101010;
    end

    for (int i = 0; i < 20; i++) begin
      if (i == 10) state = 3'd2;
      sample(cur);
    end

    for (int f = 4; f <= 8; f++)
      for (int i = 0; i < 20; i++)
        sample((BLINK && (f == 6 || f == 7)) ? BLANK_IMG : ERR_IMG);

    for (int i = 0; i < 7; i++) sample(ERR_IMG);
    reset = 1'b1;
    #1;
    chk_reset_vals();
    state = 3'd3;
    tick();
    chk_reset_vals();
    reset = 1'b0;
    k = 0;

    for (int i = 0; i < 20; i++) sample(BLANK_IMG);
    for (int i = 0; i < 20; i++) sample(SPL_IMG);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
